// File: rtl/jtpopeye_prom_loader.sv
// Palette PROM loader: steers the downloader byte stream into PROMs 4A, 5B, 5A, 3A
// in that order, one registered write strobe per accepted byte.
module jtpopeye_prom_loader #(
    parameter int LEN_4A = 32,
    parameter int LEN_5B = 32,
    parameter int LEN_5A = 256,
    parameter int LEN_3A = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dl_valid,
    input  logic [7:0] dl_data,
    output logic       dl_ready,
    output logic [7:0] prog_addr,
    output logic [7:0] prom_din,
    output logic       prom_4a_we,
    output logic       prom_5b_we,
    output logic       prom_5a_we,
    output logic       prom_3a_we,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] LAST_4A = 8'(LEN_4A - 1);
    localparam logic [7:0] LAST_5B = 8'(LEN_5B - 1);
    localparam logic [7:0] LAST_5A = 8'(LEN_5A - 1);
    localparam logic [7:0] LAST_3A = 8'(LEN_3A - 1);

    state_t     state_r, state_s;
    logic [1:0] rgn_r, rgn_s;
    logic [7:0] cnt_r, cnt_s;
    logic       accept_s;
    logic       dl_ready_r;
    logic       busy_r;
    logic       done_r;
    logic [7:0] prog_addr_r;
    logic [7:0] prom_din_r;
    logic [3:0] we_r;

    function automatic logic [7:0] last_addr(input logic [1:0] rgn);
        case (rgn)
            2'd0:    return LAST_4A;
            2'd1:    return LAST_5B;
            2'd2:    return LAST_5A;
            2'd3:    return LAST_3A;
            default: return LAST_3A;
        endcase
    endfunction

    // A byte offered alongside start is left for the restarted sequence.
    assign accept_s = (state_r == LOAD) && dl_valid && dl_ready_r && !start;

    // Next-state, region and address sequencing.
    always_comb begin
        state_s = state_r;
        rgn_s   = rgn_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = LOAD;
                    rgn_s   = 2'd0;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                if (start) begin
                    rgn_s = 2'd0;
                    cnt_s = 8'd0;
                end else if (accept_s) begin
                    state_s = STROBE;
                end else begin
                    state_s = LOAD;
                end
            end
            STROBE: begin
                if (start) begin
                    state_s = LOAD;
                    rgn_s   = 2'd0;
                    cnt_s   = 8'd0;
                end else if (cnt_r != last_addr(rgn_r)) begin
                    state_s = LOAD;
                    cnt_s   = cnt_r + 8'd1;
                end else if (rgn_r != 2'd3) begin
                    state_s = LOAD;
                    rgn_s   = rgn_r + 2'd1;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                rgn_s   = 2'd0;
                cnt_s   = 8'd0;
            end
        endcase
    end

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rgn_r       <= 2'd0;
            cnt_r       <= 8'd0;
            dl_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            prog_addr_r <= 8'd0;
            prom_din_r  <= 8'd0;
            we_r        <= 4'd0;
        end else begin
            state_r    <= state_s;
            rgn_r      <= rgn_s;
            cnt_r      <= cnt_s;
            dl_ready_r <= (state_s == LOAD);
            busy_r     <= (state_s == LOAD) || (state_s == STROBE);
            done_r     <= (state_s == DONE);
            if (accept_s) begin
                prog_addr_r <= cnt_r;
                prom_din_r  <= dl_data;
                we_r        <= 4'b0001 << rgn_r;
            end else begin
                we_r <= 4'd0;
            end
        end
    end

    assign dl_ready   = dl_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign prog_addr  = prog_addr_r;
    assign prom_din   = prom_din_r;
    assign prom_4a_we = we_r[0];
    assign prom_5b_we = we_r[1];
    assign prom_5a_we = we_r[2];
    assign prom_3a_we = we_r[3];

endmodule
